// File: rtl/interrupt_gateway.sv
// Interrupt source conditioning: resynchronise, mask, level/edge select, pending latch,
// and in-service tracking driven by the downstream priority controller's handshake.
module interrupt_gateway #(
  parameter int unsigned NO_OF_PERIPHERALS = 8,
  parameter int unsigned WIDTH             = $clog2(NO_OF_PERIPHERALS)
) (
  input  logic                         pclk,
  input  logic                         presetn,
  input  logic [1:0]                   paddr,
  input  logic                         pwrite,
  input  logic                         penable,
  input  logic [NO_OF_PERIPHERALS-1:0] pwdata,
  output logic [NO_OF_PERIPHERALS-1:0] prdata,
  output logic                         pready,
  input  logic [NO_OF_PERIPHERALS-1:0] irq_in,
  output logic [NO_OF_PERIPHERALS-1:0] interrupt_active,
  input  logic                         interrupt_valid,
  input  logic [WIDTH-1:0]             interrupt_to_be_service,
  input  logic                         interrupt_serviced
);

  localparam int unsigned N = NO_OF_PERIPHERALS;

  localparam logic [1:0] AddrMask    = 2'd0;
  localparam logic [1:0] AddrMode    = 2'd1;
  localparam logic [1:0] AddrPending = 2'd2;
  localparam logic [1:0] AddrRaw     = 2'd3;

  logic [N-1:0] r_s1, r_s2, r_s2_d;
  logic [N-1:0] r_mask, r_mode, r_pending, r_in_service;
  logic [N-1:0] r_active, r_prdata;
  logic         r_pready, r_valid_q;

  logic         w_apb_wr, w_apb_rd;
  logic         w_capture, w_retire;
  logic [N-1:0] w_rise, w_cap_sel, w_w1c;
  logic [N-1:0] w_mask_d, w_mode_d, w_pending_d, w_in_service_d;
  logic [N-1:0] w_req, w_rdata;

  assign w_apb_wr  = penable & pwrite;
  assign w_apb_rd  = penable & ~pwrite;
  assign w_rise    = r_s2 & ~r_s2_d;
  assign w_capture = interrupt_valid & ~r_valid_q;
  assign w_retire  = interrupt_valid & interrupt_serviced;

  // Out-of-range indices match no bit and are therefore ignored.
  always_comb begin
    w_cap_sel = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_cap_sel[i] = w_capture && (interrupt_to_be_service == WIDTH'(i));
    end
  end

  always_comb begin
    w_mask_d = r_mask;
    w_mode_d = r_mode;
    w_w1c    = '0;
    if (w_apb_wr) begin
      unique case (paddr)
        AddrMask:    w_mask_d = pwdata;
        AddrMode:    w_mode_d = pwdata;
        AddrPending: w_w1c    = pwdata;
        AddrRaw:     ;
        default:     ;
      endcase
    end
  end

  // A fresh edge beats any clear in the same cycle; level-mode bits never hold pending.
  assign w_pending_d = ((r_pending & ~w_w1c & ~(w_cap_sel & r_mode)) | w_rise) & w_mode_d;

  // Retire beats a simultaneous capture.
  assign w_in_service_d = w_retire ? '0 : (r_in_service | w_cap_sel);

  assign w_req = ((r_mode & r_pending) | (~r_mode & r_s2)) & r_mask & ~r_in_service;

  always_comb begin
    w_rdata = '0;
    unique case (paddr)
      AddrMask:    w_rdata = r_mask;
      AddrMode:    w_rdata = r_mode;
      AddrPending: w_rdata = r_pending;
      AddrRaw:     w_rdata = r_s2;
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_s2_d       <= '0;
      r_mask       <= '0;
      r_mode       <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
      r_valid_q    <= 1'b0;
      r_active     <= '0;
      r_prdata     <= '0;
      r_pready     <= 1'b0;
    end else begin
      r_s1         <= irq_in;
      r_s2         <= r_s1;
      r_s2_d       <= r_s2;
      r_mask       <= w_mask_d;
      r_mode       <= w_mode_d;
      r_pending    <= w_pending_d;
      r_in_service <= w_in_service_d;
      r_valid_q    <= interrupt_valid;
      r_active     <= w_req;
      r_pready     <= penable;
      if (w_apb_rd) begin
        r_prdata <= w_rdata;
      end
    end
  end

  assign interrupt_active = r_active;
  assign prdata           = r_prdata;
  assign pready           = r_pready;

endmodule
